regfile_write_ctrl: RTL

//  Write-port controller for the 8 x 32-bit enable-addressed register bank.
//  - Shares the bank's single write port (one-hot enable + common data bus) among NREQ requesters.
//  - Uses round-robin arbitration and a valid/ready handshake.
//  - Provides a clear sequencer that zeroes all NREG registers, one per cycle.
//  - Sits between the datapath/FSM masters and the register bank.

---
 rtl/regfile_write_ctrl_pkg.sv | 14 +
 rtl/regfile_write_ctrl_rr_arbiter.sv | 50 +++++
 rtl/regfile_write_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/regfile_write_ctrl_pkg.sv
// Shared types and default sizes for the register-bank write-port controller.
package regfile_write_ctrl_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int NREG_DEF   = 8;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = $clog2(NREG_DEF);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational grant searched from rr_ptr with wrap,
// pointer moves past the winner only when the grant is actually taken (en=1).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W:0]   slot;
    logic [ID_W-1:0] idx;
    logic            found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        slot   = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (slot >= (ID_W+1)'(NREQ)) begin
                slot = slot - (ID_W+1)'(NREQ);
            end
            idx = slot[ID_W-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (en && (|gnt)) begin
            rr_ptr <= (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the enable-addressed register bank: round-robin
// sharing of the single write port among NREQ masters plus a clear sweep.
module regfile_write_ctrl
    import regfile_write_ctrl_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int ADDR_W = $clog2(NREG),
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic [NREG-1:0]          rf_en,
    output logic [DATA_W-1:0]        rf_d,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int ID_W = $clog2(NREQ);

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic [ADDR_W-1:0] clr_idx;
    logic              load_clear;
    logic              accept;
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_id;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic [NREG-1:0]   wr_en;
    logic [NREG-1:0]   clr_en;
    logic [NREG-1:0]   rf_en_next;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .en     (accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign clr_last = (clr_cnt == ADDR_W'(NREG-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (clr_start) state_next = ST_CLEAR;
            ST_CLEAR: if (clr_last)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Reset gates the accept path combinationally so no ready leaks during reset.
    always_comb begin
        clr_busy   = (state == ST_CLEAR);
        accept     = (state == ST_IDLE) && !clr_start && !reset && (|gnt);
        req_ready  = accept ? gnt : '0;
        load_clear = ((state == ST_IDLE) && clr_start) || ((state == ST_CLEAR) && !clr_last);
        clr_idx    = (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
    end

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
                gnt_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Out-of-range indices match no bit, so such writes are silently dropped.
    always_comb begin
        wr_en  = '0;
        clr_en = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_en[r]  = (gnt_addr == ADDR_W'(r));
            clr_en[r] = (clr_idx == ADDR_W'(r));
        end
    end

    always_comb begin
        if (load_clear) begin
            rf_en_next = clr_en;
        end else if (accept) begin
            rf_en_next = wr_en;
        end else begin
            rf_en_next = '0;
        end
    end

    // Enable is registered one cycle ahead so it lines up with clr_busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt  <= '0;
            rf_en    <= '0;
            rf_d     <= '0;
            grant_id <= '0;
        end else begin
            clr_cnt <= ((state == ST_CLEAR) && !clr_last) ? clr_cnt + 1'b1 : '0;
            rf_en   <= rf_en_next;
            if (load_clear) begin
                rf_d <= '0;
            end else if (accept) begin
                rf_d     <= gnt_data;
                grant_id <= gnt_id;
            end
        end
    end

    a_rf_en_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(rf_en));
    a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));

endmodule
